// File: rtl/sli_pattern_sequencer.sv
// Structured-light pattern sequencer: steps (frq, fra), fires one fixed-length
// camera trigger per displayed pattern and waits for camera ready between patterns.
module sli_pattern_sequencer #(
    parameter int          N_FRQ       = 3,
    parameter int          N_FRA       = 8,
    parameter logic [19:0] EXP_CYCLES  = 20'h80000,
    parameter logic [3:0]  TIMEOUT_FRM = 4'd15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_vsync,
    input  logic       in_blank,
    input  logic       mode,
    input  logic       run,
    input  logic       rdy,
    output logic [1:0] frq,
    output logic [2:0] fra,
    output logic       trig,
    output logic       hold,
    output logic       f_frm,
    output logic       seq_done,
    output logic       err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FRAME  = 3'd2,
        S_EXPOSE = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    localparam logic [1:0] FRQ_LAST = 2'(N_FRQ - 1);
    localparam logic [2:0] FRA_LAST = 3'(N_FRA - 1);

    state_t      state_q, state_d;
    logic [1:0]  frq_q, frq_d;
    logic [2:0]  fra_q, fra_d;
    logic        trig_q, trig_d;
    logic        hold_q, hold_d;
    logic        f_frm_q, f_frm_d;
    logic        seq_done_q, seq_done_d;
    logic        err_q, err_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  vcnt_q, vcnt_d;
    logic        vs_d_q, bl_d_q;

    logic vs_rise, bl_fall;
    assign vs_rise = in_vsync & ~vs_d_q;
    assign bl_fall = ~in_blank & bl_d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            frq_q      <= 2'd0;
            fra_q      <= 3'd0;
            trig_q     <= 1'b0;
            hold_q     <= 1'b0;
            f_frm_q    <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 20'd0;
            vcnt_q     <= 4'd0;
            vs_d_q     <= 1'b1;
            bl_d_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frq_q      <= frq_d;
            fra_q      <= fra_d;
            trig_q     <= trig_d;
            hold_q     <= hold_d;
            f_frm_q    <= f_frm_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            vcnt_q     <= vcnt_d;
            vs_d_q     <= in_vsync;
            bl_d_q     <= in_blank;
        end
    end

    // Camera handshake: hold is high while the pattern waits for the camera;
    // the edge that samples rdy high in that wait drops hold and advances the index.
    always_comb begin
        state_d    = state_q;
        frq_d      = frq_q;
        fra_d      = fra_q;
        trig_d     = trig_q;
        hold_d     = hold_q;
        seq_done_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        vcnt_d     = vcnt_q;

        if (mode) begin
            state_d = S_IDLE;
            frq_d   = 2'd0;
            fra_d   = 3'd0;
            trig_d  = 1'b0;
            hold_d  = 1'b0;
            cnt_d   = 20'd0;
            vcnt_d  = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frq_d  = 2'd0;
                    fra_d  = 3'd0;
                    trig_d = 1'b0;
                    hold_d = 1'b0;
                    if (run) begin
                        state_d = S_ARM;
                        err_d   = 1'b0;
                    end
                end
                S_ARM: begin
                    if (vs_rise) state_d = S_FRAME;
                end
                S_FRAME: begin
                    if (bl_fall) begin
                        state_d = S_EXPOSE;
                        cnt_d   = EXP_CYCLES;
                        trig_d  = 1'b1;
                    end
                end
                S_EXPOSE: begin
                    if (cnt_q == 20'd1) begin
                        state_d = S_WAIT;
                        trig_d  = 1'b0;
                        hold_d  = 1'b1;
                        cnt_d   = 20'd0;
                        vcnt_d  = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 20'd1;
                    end
                end
                S_WAIT: begin
                    // rdy wins over a timeout-reaching vsync in the same cycle.
                    if (rdy) begin
                        hold_d = 1'b0;
                        if (fra_q < FRA_LAST) begin
                            fra_d = fra_q + 3'd1;
                        end else begin
                            fra_d = 3'd0;
                            if (frq_q < FRQ_LAST) begin
                                frq_d = frq_q + 2'd1;
                            end else begin
                                frq_d      = 2'd0;
                                seq_done_d = 1'b1;
                            end
                        end
                        if (run) begin
                            state_d = S_ARM;
                        end else begin
                            state_d = S_IDLE;
                            frq_d   = 2'd0;
                            fra_d   = 3'd0;
                        end
                    end else if (vs_rise) begin
                        vcnt_d = vcnt_q + 4'd1;
                        if (vcnt_q + 4'd1 == TIMEOUT_FRM) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            hold_d  = 1'b0;
                            frq_d   = 2'd0;
                            fra_d   = 3'd0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        f_frm_d = (fra_d == 3'd0) && (state_d != S_IDLE);
    end

    assign frq       = frq_q;
    assign fra       = fra_q;
    assign trig      = trig_q;
    assign hold      = hold_q;
    assign f_frm     = f_frm_q;
    assign seq_done  = seq_done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sli_pattern_sequencer.sv
// Bench for sli_pattern_sequencer: random-length video frames, an expected pattern
// queue derived from the index stepping rules, and directed abort/timeout/reset steps.
module tb_sli_pattern_sequencer;

    localparam int N_FRQ = 3;
    localparam int N_FRA = 8;
    localparam int EXP   = 16;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_FRAME = 3'd2;

    logic       clk, rstn, in_vsync, in_blank, mode, run, rdy;
    logic       rdy_auto, rdy_man;
    logic [1:0] frq;
    logic [2:0] fra;
    logic       trig, hold, f_frm, seq_done, err;
    logic [2:0] dbg_state;

    assign rdy = rdy_auto | rdy_man;

    sli_pattern_sequencer #(
        .N_FRQ      (N_FRQ),
        .N_FRA      (N_FRA),
        .EXP_CYCLES (20'd16),
        .TIMEOUT_FRM(4'd3)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vsync (in_vsync),
        .in_blank (in_blank),
        .mode     (mode),
        .run      (run),
        .rdy      (rdy),
        .frq      (frq),
        .fra      (fra),
        .trig     (trig),
        .hold     (hold),
        .f_frm    (f_frm),
        .seq_done (seq_done),
        .err      (err),
        .dbg_state(dbg_state)
    );

    int         checks = 0;
    int         errors = 0;
    int         trig_cnt = 0;
    int         seq_cnt = 0;
    int         vs_edges = 0;
    logic       active_en = 1'b1;
    logic       sb_en = 1'b0;
    logic       auto_rdy = 1'b0;
    logic [4:0] exp_q[$];

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern k is shown as frequency (k / N_FRA) mod N_FRQ, phase k mod N_FRA.
    task automatic push_patterns(input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({2'((k / N_FRA) % N_FRQ), 3'(k % N_FRA)});
    endtask

    // Video source: vsync for 2 cycles at frame start, one active window per frame.
    initial begin
        int   flen, act, alen;
        logic act_on;
        in_vsync = 1'b0;
        in_blank = 1'b1;
        forever begin
            flen   = $urandom_range(70, 40);
            act    = $urandom_range(8, 3);
            alen   = $urandom_range(flen - act - 4, 20);
            act_on = active_en;
            for (int c = 0; c < flen; c++) begin
                @(posedge clk);
                #1;
                in_vsync = (c < 2);
                in_blank = !(act_on && c >= act && c < act + alen);
                if (c == 0) vs_edges++;
            end
        end
    end

    // Camera model: answers each hold rise with a one-cycle rdy ten cycles later.
    initial begin
        logic hp;
        hp = 1'b0;
        rdy_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_rdy && hold && !hp) begin
                repeat (10) @(posedge clk);
                #1 rdy_auto = 1'b1;
                @(posedge clk);
                #1 rdy_auto = 1'b0;
            end
            hp = hold;
        end
    end

    // Scoreboard: trigger alignment, index order, trigger length, seq_done placement.
    initial begin
        logic       trig_prev, bl_h0, bl_h1;
        logic [4:0] prev_idx, e;
        int         width;
        trig_prev = 1'b0;
        bl_h0 = 1'b1;
        bl_h1 = 1'b1;
        prev_idx = 5'd0;
        width = 0;
        forever begin
            @(negedge clk);
            if (trig && !trig_prev) begin
                trig_cnt++;
                width = 0;
                check("trig_align_blank_fall", 32'({bl_h1, bl_h0}), 32'(2'b10));
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        check("trig_unexpected", 32'(trig_cnt), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("trig_index", 32'({frq, fra}), 32'(e));
                        check("f_frm_at_trig", 32'(f_frm), 32'(e[2:0] == 3'd0));
                    end
                end
            end
            if (trig) width++;
            if (!trig && trig_prev && sb_en) begin
                check("trig_width", 32'(width), 32'(EXP));
                check("hold_at_trig_fall", 32'(hold), 32'(1));
            end
            if (seq_done) begin
                seq_cnt++;
                if (sb_en) begin
                    check("seq_done_from_last", 32'(prev_idx), 32'({2'd2, 3'd7}));
                    check("seq_done_wrap_idx", 32'({frq, fra}), 32'(0));
                end
            end
            trig_prev = trig;
            bl_h1 = bl_h0;
            bl_h0 = in_blank;
            prev_idx = {frq, fra};
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (dbg_state !== s && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_trigs(input int target, input int budget, input string tag);
        int n = 0;
        while (trig_cnt < target && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 32'(trig_cnt), 32'(target));
    endtask

    task automatic wait_hold(input int budget, input string tag);
        int n = 0;
        while (hold !== 1'b1 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, 32'(hold), 32'(1));
    endtask

    // Returns just after the video source drove the target vsync rise, before the DUT samples it.
    task automatic wait_vs(input int target, input int budget, input string tag);
        int n = 0;
        while (vs_edges < target && n < budget) begin
            @(posedge clk); #2; n++;
        end
        check(tag, 32'(vs_edges), 32'(target));
    endtask

    initial begin
        int t0, base;
        rstn = 1'b0; mode = 1'b0; run = 1'b0; rdy_man = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'(0));
        check("rst_hold", 32'(hold), 32'(0));
        check("rst_f_frm", 32'(f_frm), 32'(0));
        check("rst_seq_done", 32'(seq_done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_idx", 32'({frq, fra}), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Full sequence: 24 patterns plus the wrap-around pattern after run drops
        push_patterns(25);
        sb_en = 1'b1; auto_rdy = 1'b1; run = 1'b1;
        while (seq_cnt < 1 && trig_cnt < 40) begin @(negedge clk); #1; end
        check("seq_done_seen", 32'(seq_cnt), 32'(1));
        run = 1'b0;
        wait_state(ST_IDLE, 3000, "seq_end_idle");
        check("seq_trig_count", 32'(trig_cnt), 32'(25));
        check("seq_queue_empty", 32'(exp_q.size()), 32'(0));
        check("seq_end_idx", 32'({frq, fra}), 32'(0));
        check("seq_done_once", 32'(seq_cnt), 32'(1));
        wait_vs(vs_edges + 2, 400, "seq_idle_frames");
        check("seq_no_extra_trig", 32'(trig_cnt), 32'(25));

        // Frames with no active pixels produce no trigger
        sb_en = 1'b0; auto_rdy = 1'b0; active_en = 1'b0;
        @(negedge clk); #1;
        run = 1'b1;
        t0 = trig_cnt;
        wait_vs(vs_edges + 3, 600, "blank_frames");
        check("blank_no_trig", 32'(trig_cnt), 32'(t0));
        check("blank_state_frame", 32'(dbg_state), 32'(ST_FRAME));
        active_en = 1'b1;
        wait_trigs(t0 + 1, 600, "active_frame_trig");
        check("active_trig_idx", 32'({frq, fra}), 32'(0));
        check("active_f_frm", 32'(f_frm), 32'(1));
        run = 1'b0;

        // rdy never arrives: abort on the third vsync rise after hold
        wait_hold(100, "timeout_hold_rise");
        base = vs_edges;
        wait_vs(base + 2, 400, "timeout_vs2");
        @(negedge clk); @(negedge clk);
        check("timeout_err_vs2", 32'(err), 32'(0));
        check("timeout_hold_vs2", 32'(hold), 32'(1));
        wait_vs(base + 3, 200, "timeout_vs3");
        @(negedge clk);
        check("timeout_err_before", 32'(err), 32'(0));
        @(negedge clk);
        check("timeout_err_set", 32'(err), 32'(1));
        check("timeout_hold_low", 32'(hold), 32'(0));
        check("timeout_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("timeout_idx_zero", 32'({frq, fra}), 32'(0));
        mode = 1'b1;
        repeat (3) @(negedge clk);
        check("err_kept_by_mode", 32'(err), 32'(1));
        mode = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("rearm_err_clear", 32'(err), 32'(0));
        check("rearm_state_arm", 32'(dbg_state), 32'(ST_ARM));
        check("rearm_idx_zero", 32'({frq, fra}), 32'(0));

        // run dropped during the (1,3) exposure
        push_patterns(12);
        sb_en = 1'b1; auto_rdy = 1'b1;
        t0 = trig_cnt;
        wait_trigs(t0 + 12, 3000, "run_drop_reach_1_3");
        run = 1'b0;
        check("run_drop_idx", 32'({frq, fra}), 32'({2'd1, 3'd3}));
        wait_state(ST_IDLE, 200, "run_drop_idle");
        check("run_drop_idx_zero", 32'({frq, fra}), 32'(0));
        check("run_drop_queue_empty", 32'(exp_q.size()), 32'(0));
        wait_vs(vs_edges + 2, 400, "run_drop_frames");
        check("run_drop_no_trig", 32'(trig_cnt), 32'(t0 + 12));

        // Pass-through forced at cnt=8 of the (0,2) exposure
        push_patterns(3);
        run = 1'b1;
        t0 = trig_cnt;
        wait_trigs(t0 + 3, 800, "mode_reach_0_2");
        sb_en = 1'b0; auto_rdy = 1'b0;
        repeat (8) @(posedge clk);
        #1 mode = 1'b1;
        @(negedge clk);
        check("mode_trig_still_high", 32'(trig), 32'(1));
        @(negedge clk);
        check("mode_trig_low", 32'(trig), 32'(0));
        check("mode_hold_low", 32'(hold), 32'(0));
        check("mode_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("mode_idx_zero", 32'({frq, fra}), 32'(0));
        check("mode_f_frm_low", 32'(f_frm), 32'(0));
        mode = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);

        // rdy in the same cycle as the timeout-reaching vsync rise
        run = 1'b1;
        t0 = trig_cnt;
        wait_trigs(t0 + 1, 600, "race_trig");
        wait_hold(100, "race_hold_rise");
        base = vs_edges;
        wait_vs(base + 3, 600, "race_vs3");
        rdy_man = 1'b1;
        @(posedge clk);
        #1 rdy_man = 1'b0;
        @(negedge clk);
        check("race_err_zero", 32'(err), 32'(0));
        check("race_hold_low", 32'(hold), 32'(0));
        check("race_idx_adv", 32'({frq, fra}), 32'({2'd0, 3'd1}));
        check("race_state_arm", 32'(dbg_state), 32'(ST_ARM));

        // Asynchronous reset while trig is high
        t0 = trig_cnt;
        wait_trigs(t0 + 1, 600, "reset_trig");
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("areset_trig", 32'(trig), 32'(0));
        check("areset_hold", 32'(hold), 32'(0));
        check("areset_f_frm", 32'(f_frm), 32'(0));
        check("areset_seq_done", 32'(seq_done), 32'(0));
        check("areset_err", 32'(err), 32'(0));
        check("areset_idx", 32'({frq, fra}), 32'(0));
        check("areset_state", 32'(dbg_state), 32'(ST_IDLE));
        run = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
